// File: rtl/tpu_tile_scheduler_if.sv
// Scheduler-facing bundle: host start handshake plus systolic array and global buffer signals.
// master = scheduler side, slave = host/array/buffer side.
interface tpu_tile_scheduler_if #(
   parameter int ADDR_W = 16,
   parameter int DIM_W  = 8
);
   logic              in_valid;
   logic [DIM_W-1:0]  K;
   logic [DIM_W-1:0]  M;
   logic [DIM_W-1:0]  N;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] A_index;
   logic [ADDR_W-1:0] B_index;
   logic              sa_clear;
   logic              sa_feed;
   logic              sa_done;
   logic [1:0]        sa_row_sel;
   logic [127:0]      sa_row_data;
   logic              C_wr_en;
   logic [ADDR_W-1:0] C_index;
   logic [127:0]      C_data_in;

   modport master (
      input  in_valid, K, M, N, sa_done, sa_row_data,
      output busy, done, A_index, B_index, sa_clear, sa_feed,
             sa_row_sel, C_wr_en, C_index, C_data_in
   );

   modport slave (
      output in_valid, K, M, N, sa_done, sa_row_data,
      input  busy, done, A_index, B_index, sa_clear, sa_feed,
             sa_row_sel, C_wr_en, C_index, C_data_in
   );
endinterface

// File: rtl/tpu_tile_scheduler.sv
// Walks 4x4 output tiles (n outer, m inner) for an MxK * KxN multiply on a 4x4 systolic array.
// Optional performance counters (cycle_cnt, tile_cnt) enabled by defining TPU_SCHED_PERF_CNT_EN.
module tpu_tile_scheduler #(
   parameter int ADDR_W = 16,
   parameter int DIM_W  = 8
) (
   input  logic clk,
   input  logic rst_n,
   tpu_tile_scheduler_if.master bus
`ifdef TPU_SCHED_PERF_CNT_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [15:0] tile_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_FEED, S_WAIT, S_WB, S_NEXT, S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [DIM_W-1:0]  r_K, r_M, r_N;
   logic [DIM_W-1:0]  r_k, r_mTile, r_nTile;
   logic [1:0]        r_row;

   logic [DIM_W:0]    w_mt, w_nt;
   logic              w_lastM, w_lastN, w_lastK, w_anyZero, w_rowValid;
   logic [ADDR_W-1:0] w_aIdx, w_bIdx, w_cRow, w_cIdx;

   // Tile counts are ceil(dim/4), held one bit wider so M=255 cannot wrap.
   assign w_mt       = ((DIM_W+1)'(r_M) + (DIM_W+1)'(3)) >> 2;
   assign w_nt       = ((DIM_W+1)'(r_N) + (DIM_W+1)'(3)) >> 2;
   assign w_lastM    = ((DIM_W+1)'(r_mTile) + (DIM_W+1)'(1)) >= w_mt;
   assign w_lastN    = ((DIM_W+1)'(r_nTile) + (DIM_W+1)'(1)) >= w_nt;
   assign w_lastK    = (r_k == (r_K - DIM_W'(1)));
   assign w_anyZero  = (bus.K == '0) || (bus.M == '0) || (bus.N == '0);

   assign w_aIdx     = ADDR_W'(r_mTile) * ADDR_W'(r_K) + ADDR_W'(r_k);
   assign w_bIdx     = ADDR_W'(r_nTile) * ADDR_W'(r_K) + ADDR_W'(r_k);
   assign w_cRow     = ADDR_W'({r_mTile, 2'b00}) + ADDR_W'(r_row);
   assign w_cIdx     = ADDR_W'(r_nTile) * ADDR_W'(r_M) + w_cRow;
   assign w_rowValid = w_cRow < ADDR_W'(r_M);

   assign bus.C_data_in = bus.sa_row_data;

   // State register; reset aborts any tile in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next state and outputs; every output is forced to zero outside its owning state.
   always_comb begin
      w_next         = r_state;
      bus.busy       = (r_state != S_IDLE);
      bus.done       = 1'b0;
      bus.sa_clear   = 1'b0;
      bus.sa_feed    = 1'b0;
      bus.A_index    = '0;
      bus.B_index    = '0;
      bus.sa_row_sel = 2'd0;
      bus.C_wr_en    = 1'b0;
      bus.C_index    = '0;
      case (r_state)
         S_IDLE: begin
            if (bus.in_valid) w_next = w_anyZero ? S_DONE : S_CLEAR;
         end
         S_CLEAR: begin
            bus.sa_clear = 1'b1;
            w_next       = S_FEED;
         end
         S_FEED: begin
            bus.sa_feed = 1'b1;
            bus.A_index = w_aIdx;
            bus.B_index = w_bIdx;
            if (w_lastK) w_next = S_WAIT;
         end
         S_WAIT: begin
            if (bus.sa_done) w_next = S_WB;
         end
         S_WB: begin
            bus.sa_row_sel = r_row;
            bus.C_index    = w_cIdx;
            bus.C_wr_en    = w_rowValid;
            if (r_row == 2'd3) w_next = S_NEXT;
         end
         S_NEXT: begin
            w_next = (w_lastM && w_lastN) ? S_DONE : S_CLEAR;
         end
         S_DONE: begin
            bus.done = 1'b1;
            w_next   = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Dimension latches and the tile/k/row walkers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_K     <= '0;
         r_M     <= '0;
         r_N     <= '0;
         r_k     <= '0;
         r_mTile <= '0;
         r_nTile <= '0;
         r_row   <= 2'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_K     <= bus.K;
                  r_M     <= bus.M;
                  r_N     <= bus.N;
                  r_k     <= '0;
                  r_mTile <= '0;
                  r_nTile <= '0;
               end
            end
            S_CLEAR: r_k   <= '0;
            S_FEED:  r_k   <= r_k + DIM_W'(1);
            S_WAIT:  r_row <= 2'd0;
            S_WB:    r_row <= r_row + 2'd1;
            S_NEXT: begin
               if (!w_lastM) begin
                  r_mTile <= r_mTile + DIM_W'(1);
               end else if (!w_lastN) begin
                  r_mTile <= '0;
                  r_nTile <= r_nTile + DIM_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef TPU_SCHED_PERF_CNT_EN
   logic [31:0] r_cycleCnt;
   logic [15:0] r_tileCnt;

   // cycle_cnt restarts on each accepted job and freezes once back in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycleCnt <= '0;
         r_tileCnt  <= '0;
      end else begin
         if (r_state == S_IDLE && bus.in_valid) r_cycleCnt <= '0;
         else if (r_state != S_IDLE)            r_cycleCnt <= r_cycleCnt + 32'd1;
         if (r_state == S_NEXT)                 r_tileCnt  <= r_tileCnt + 16'd1;
      end
   end

   assign cycle_cnt = r_cycleCnt;
   assign tile_cnt  = r_tileCnt;
`endif

endmodule
